microc_stack: RTL and testbench

MICROC_STACK -- requirements
Module: microc_stack

---
 rtl/microc_stack.sv | 188 ++++++++++++++++++
 tb/tb_microc_stack.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/microc_stack.sv
`default_nettype none
// ============================================================================
// Module   : microc_stack
// Purpose  : Single-cycle microcontroller datapath with a hardware return
//            stack. Holds the program counter, a register file with a
//            hard-wired zero register, an 8-function ALU, a registered zero
//            flag and a bounded call/return stack with a sticky fault flag.
// Ports    : clk       - rising-edge clock
//            reset     - synchronous active-low reset
//            instr     - instruction fetched at pc (same cycle)
//            s_inc     - 1: pc+1, 0: jump to instr[PW-1:0]
//            s_inm     - 1: write immediate, 0: write ALU result
//            we3       - register-file write enable
//            wez       - zero-flag load enable
//            Op        - ALU operation select
//            s_call    - subroutine call request
//            s_ret     - subroutine return request
//            pc        - program counter / program memory address
//            Opcode    - instr[IW-1:IW-OPW]
//            z         - registered zero flag
//            sp        - number of occupied stack entries
//            stack_err - sticky stack fault flag
// Revision : 1.0 - initial release
// ============================================================================
module microc_stack #(
   parameter int DW  = 8,
   parameter int RA  = 4,
   parameter int PW  = 10,
   parameter int IW  = 16,
   parameter int OPW = 6,
   parameter int SD  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [IW-1:0]             instr,
   input  logic                      s_inc,
   input  logic                      s_inm,
   input  logic                      we3,
   input  logic                      wez,
   input  logic [2:0]                Op,
   input  logic                      s_call,
   input  logic                      s_ret,
   output logic [PW-1:0]             pc,
   output logic [OPW-1:0]            Opcode,
   output logic                      z,
   output logic [$clog2(SD+1)-1:0]   sp,
   output logic                      stack_err
);

   localparam int SPW = $clog2(SD + 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DW-1:0]  r_regs [2**RA];
   logic [PW-1:0]  r_stack [SD];
   logic [PW-1:0]  r_pc;
   logic           r_z;
   logic [SPW-1:0] r_sp;
   logic           r_stack_err;

   // ------------------------------------------------------------------------
   // Instruction fields
   // ------------------------------------------------------------------------
   logic [RA-1:0] w_wa3;
   logic [RA-1:0] w_ra2;
   logic [RA-1:0] w_ra1;
   logic [DW-1:0] w_inm;
   logic [PW-1:0] w_dir;

   assign w_wa3  = instr[RA-1:0];
   assign w_ra2  = instr[2*RA-1:RA];
   assign w_ra1  = instr[3*RA-1:2*RA];
   assign w_inm  = instr[DW+RA-1:RA];
   assign w_dir  = instr[PW-1:0];
   assign Opcode = instr[IW-1 -: OPW];

   // ------------------------------------------------------------------------
   // Register read, ALU and write-data select
   // ------------------------------------------------------------------------
   logic [DW-1:0] w_rd1;
   logic [DW-1:0] w_rd2;
   logic [DW-1:0] w_alu;
   logic [DW-1:0] w_wd3;

   // Register 0 is never written after reset, so a plain array read of it
   // always yields zero.
   assign w_rd1 = r_regs[w_ra1];
   assign w_rd2 = r_regs[w_ra2];

   always_comb begin
      w_alu = '0;
      case (Op)
         3'b000:  w_alu = w_rd1;
         3'b001:  w_alu = ~w_rd1;
         3'b010:  w_alu = w_rd1 + w_rd2;
         3'b011:  w_alu = w_rd1 - w_rd2;
         3'b100:  w_alu = w_rd1 & w_rd2;
         3'b101:  w_alu = w_rd1 | w_rd2;
         3'b110:  w_alu = -w_rd1;
         default: w_alu = -w_rd2;
      endcase
   end

   assign w_wd3 = s_inm ? w_inm : w_alu;

   // ------------------------------------------------------------------------
   // Next-PC and stack control
   // ------------------------------------------------------------------------
   logic [PW-1:0] w_pc_inc;
   logic [PW-1:0] w_pc_next;
   logic [PW-1:0] w_top;
   logic          w_push;
   logic          w_pop;
   logic          w_err;
   logic          w_full;
   logic          w_empty;

   assign w_pc_inc = r_pc + 1'b1;   // wraps naturally at 2^PW
   assign w_full   = (r_sp == SPW'(SD));
   assign w_empty  = (r_sp == '0);

   // Top-of-stack is entry sp-1; decoded per entry to keep index widths exact.
   always_comb begin
      w_top = '0;
      for (int i = 0; i < SD; i++) begin
         if (r_sp == SPW'(i + 1)) w_top = r_stack[i];
      end
   end

   always_comb begin
      w_pc_next = w_pc_inc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err     = 1'b0;
      if (s_call && s_ret) begin
         w_err = 1'b1;
      end else if (s_ret) begin
         if (w_empty) begin
            w_err = 1'b1;
         end else begin
            w_pc_next = w_top;
            w_pop     = 1'b1;
         end
      end else if (s_call) begin
         w_pc_next = w_dir;
         // A call on a full stack still jumps; only the return address is lost.
         if (w_full) w_err = 1'b1;
         else        w_push = 1'b1;
      end else if (!s_inc) begin
         w_pc_next = w_dir;
      end
   end

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc        <= '0;
         r_z         <= 1'b0;
         r_sp        <= '0;
         r_stack_err <= 1'b0;
         for (int i = 0; i < 2**RA; i++) r_regs[i] <= '0;
      end else begin
         r_pc <= w_pc_next;
         if (w_push)      r_sp <= r_sp + 1'b1;
         else if (w_pop)  r_sp <= r_sp - 1'b1;
         if (w_err)       r_stack_err <= 1'b1;
         if (wez)         r_z <= (w_alu == '0);
         if (we3 && (w_wa3 != '0)) r_regs[w_wa3] <= w_wd3;
      end
   end

   // Stack storage needs no reset: entries are only visible below sp.
   always_ff @(posedge clk) begin
      for (int i = 0; i < SD; i++) begin
         if (reset && w_push && (r_sp == SPW'(i))) r_stack[i] <= w_pc_inc;
      end
   end

   assign pc        = r_pc;
   assign z         = r_z;
   assign sp        = r_sp;
   assign stack_err = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_microc_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_microc_stack
// Purpose  : Directed self-checking bench for microc_stack (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_microc_stack;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        s_inc, s_inm, we3, wez, s_call, s_ret;
   logic [2:0]  Op;
   logic [9:0]  pc;
   logic [5:0]  Opcode;
   logic        z;
   logic [2:0]  sp;
   logic        stack_err;

   int n_vec = 0;
   int n_bad = 0;

   microc_stack dut (
      .clk       (clk),
      .reset     (reset),
      .instr     (instr),
      .s_inc     (s_inc),
      .s_inm     (s_inm),
      .we3       (we3),
      .wez       (wez),
      .Op        (Op),
      .s_call    (s_call),
      .s_ret     (s_ret),
      .pc        (pc),
      .Opcode    (Opcode),
      .z         (z),
      .sp        (sp),
      .stack_err (stack_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset  = 1'b1;
      s_inc  = 1'b1;
      s_inm  = 1'b0;
      we3    = 1'b0;
      wez    = 1'b0;
      Op     = 3'b000;
      s_call = 1'b0;
      s_ret  = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      instr = 16'h0000;
      tick();
      reset = 1'b1;
   endtask

   logic [7:0] alu_exp [8];
   logic [9:0] ret_pc  [5];
   logic [2:0] ret_sp  [5];

   initial begin
      // r1 = A5, r2 = 4A
      alu_exp = '{8'hA5, 8'h5A, 8'hEF, 8'h5B, 8'h00, 8'hEF, 8'h5B, 8'hB6};
      ret_pc  = '{10'h031, 10'h021, 10'h011, 10'h007, 10'h008};
      ret_sp  = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

      // ---- reset and sequential fetch ----
      do_reset();
      check("rst_pc", pc, 0);
      check("rst_z", z, 0);
      check("rst_sp", sp, 0);
      check("rst_err", stack_err, 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("seq_pc", pc, i);
      end
      check("seq_z", z, 0);
      check("seq_sp", sp, 0);

      // ---- opcode field ----
      instr = 16'hFC00;
      #1;
      check("opcode", Opcode, 6'h3F);

      // ---- load immediate r1 = A5 ----
      instr = 16'h0A51; s_inm = 1'b1; we3 = 1'b1;
      tick();
      check("li_r1", dut.r_regs[1], 8'hA5);

      // ---- r2 = r1 + r1 ----
      instr = 16'h0112; s_inm = 1'b0; Op = 3'b010; wez = 1'b1;
      tick();
      check("add_r2", dut.r_regs[2], 8'h4A);
      check("add_z", z, 0);

      // ---- all ALU ops into r3 (A=r1, B=r2) ----
      instr = 16'h0123;
      for (int op = 0; op < 8; op++) begin
         Op = op[2:0];
         tick();
         check($sformatf("alu%0d_r3", op), dut.r_regs[3], alu_exp[op]);
         check($sformatf("alu%0d_z", op), z, (alu_exp[op] == 8'h00));
      end

      // ---- zero flag set then held ----
      instr = 16'h0110; Op = 3'b011; we3 = 1'b0; wez = 1'b1;
      tick();
      check("sub_z", z, 1);
      Op = 3'b010; wez = 1'b0;
      tick();
      check("z_hold", z, 1);

      // ---- register 0 ignores writes ----
      instr = 16'h0100; Op = 3'b000; wez = 1'b1;
      tick();
      check("z_clr", z, 0);
      instr = 16'h0FF0; s_inm = 1'b1; we3 = 1'b1; wez = 1'b0;
      tick();
      instr = 16'h0000; s_inm = 1'b0; we3 = 1'b0; wez = 1'b1;
      tick();
      check("r0_zero", z, 1);

      // ---- call / return ----
      do_reset();
      s_inc = 1'b0; instr = 16'h0005;
      tick();
      check("jmp_pc", pc, 10'h005);
      s_inc = 1'b1; s_call = 1'b1; instr = 16'h0100;
      tick();
      check("call_pc", pc, 10'h100);
      check("call_sp", sp, 1);
      s_call = 1'b0; s_ret = 1'b1;
      tick();
      check("ret_pc", pc, 10'h006);
      check("ret_sp", sp, 0);
      check("ret_err", stack_err, 0);

      // ---- overflow / underflow ----
      s_ret = 1'b0; s_call = 1'b1;
      for (int i = 0; i < 5; i++) begin
         instr = 16'((i + 1) * 16);
         tick();
         check($sformatf("ncall%0d_pc", i), pc, (i + 1) * 16);
         check($sformatf("ncall%0d_sp", i), sp, (i < 4) ? i + 1 : 4);
         check($sformatf("ncall%0d_err", i), stack_err, (i == 4));
      end
      s_call = 1'b0; s_ret = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("nret%0d_pc", i), pc, ret_pc[i]);
         check($sformatf("nret%0d_sp", i), sp, ret_sp[i]);
      end
      check("under_err", stack_err, 1);

      // ---- simultaneous call and return ----
      do_reset();
      check("rst2_err", stack_err, 0);
      s_call = 1'b1; instr = 16'h0007;
      tick();
      check("c7_pc", pc, 10'h007);
      s_ret = 1'b1;
      tick();
      check("both_pc", pc, 10'h008);
      check("both_sp", sp, 1);
      check("both_err", stack_err, 1);
      s_call = 1'b0;
      tick();
      check("both_ret_pc", pc, 10'h001);
      check("both_ret_sp", sp, 0);

      // ---- pc+1 wrap, for both increment and pushed return address ----
      do_reset();
      s_inc = 1'b0; instr = 16'h03FF;
      tick();
      s_inc = 1'b1;
      tick();
      check("wrap_pc", pc, 10'h000);
      s_inc = 1'b0; instr = 16'h03FF;
      tick();
      s_inc = 1'b1; s_call = 1'b1; instr = 16'h0123;
      tick();
      check("wcall_pc", pc, 10'h123);
      s_call = 1'b0; s_ret = 1'b1;
      tick();
      check("wret_pc", pc, 10'h000);
      check("wret_err", stack_err, 0);

      // ---- reset overrides an in-progress call ----
      s_ret = 1'b0; instr = 16'h0A51; s_inm = 1'b1; we3 = 1'b1;
      tick();
      instr = 16'h0110; s_inm = 1'b0; we3 = 1'b0; Op = 3'b011; wez = 1'b1;
      tick();
      check("pre_z", z, 1);
      s_call = 1'b1; s_ret = 1'b1; wez = 1'b0; instr = 16'h0200;
      tick();
      check("pre_err", stack_err, 1);
      s_ret = 1'b0;
      tick();
      check("pre_sp", sp, 1);
      reset = 1'b0; s_call = 1'b1; we3 = 1'b1; s_inm = 1'b1; wez = 1'b1; instr = 16'h0A51;
      tick();
      check("mid_pc", pc, 0);
      check("mid_z", z, 0);
      check("mid_sp", sp, 0);
      check("mid_err", stack_err, 0);
      check("mid_r1", dut.r_regs[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
